mux4_reg: RTL and testbench

- 4-to-1 multiplexer selecting one of four WIDTH-bit data inputs by a 2-bit select.
- Provides a combinational output and a registered output with one cycle of latency.
- The registered path carries a valid flag and a select-change pulse.
- Generic datapath steering leaf used wherever a pipelined 4:1 selection is needed.

---
 rtl/mux4_reg.sv | 95 +++++++++
 tb/tb_mux4_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux4_reg.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_reg
//  Purpose  : 4-to-1 WIDTH-bit multiplexer with a combinational output and a
//             registered output. The registered path carries a valid flag,
//             the captured select code and a select-change pulse.
//  Options  : MUX4_REG_PARITY_EN - when defined, adds output z_par, the even
//             parity (XOR reduction) of the value captured into z.
//  Revision : 1.0 - initial release
// ============================================================================
module mux4_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] z_comb,
    output logic [WIDTH-1:0] z,
    output logic             z_valid,
    output logic [1:0]       sel_q,
`ifdef MUX4_REG_PARITY_EN
    output logic             z_par,
`endif
    output logic             sel_chg
);

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_differs;

    logic [WIDTH-1:0] r_z;
    logic             r_z_valid;
    logic [1:0]       r_sel_q;
    logic             r_sel_chg;

    // Full decode of the select code; every code has its own arm.
    always_comb begin
        w_sel_data = d0;
        case (sel)
            2'd0: w_sel_data = d0;
            2'd1: w_sel_data = d1;
            2'd2: w_sel_data = d2;
            2'd3: w_sel_data = d3;
        endcase
    end

    // A change is only meaningful against a previous capture that is still
    // valid, so the first capture after reset or an en=0 gap never pulses.
    assign w_sel_differs = r_z_valid && (sel != r_sel_q);

    // Registered path: capture on en, otherwise hold data/select and drop flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z       <= '0;
            r_z_valid <= 1'b0;
            r_sel_q   <= 2'd0;
            r_sel_chg <= 1'b0;
        end else if (en) begin
            r_z       <= w_sel_data;
            r_z_valid <= 1'b1;
            r_sel_q   <= sel;
            r_sel_chg <= w_sel_differs;
        end else begin
            r_z_valid <= 1'b0;
            r_sel_chg <= 1'b0;
        end
    end

`ifdef MUX4_REG_PARITY_EN
    logic r_z_par;

    // Parity tracks the value captured into z and holds with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z_par <= 1'b0;
        end else if (en) begin
            r_z_par <= ^w_sel_data;
        end
    end

    assign z_par = r_z_par;
`endif

    assign z_comb  = w_sel_data;
    assign z       = r_z;
    assign z_valid = r_z_valid;
    assign sel_q   = r_sel_q;
    assign sel_chg = r_sel_chg;

endmodule
`default_nettype wire

// File: tb/tb_mux4_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux4_reg
//  Purpose  : Directed self-checking bench for mux4_reg (WIDTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_reg;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] d0, d1, d2, d3;
    logic [1:0]   sel;
    logic [W-1:0] z_comb;
    logic [W-1:0] z;
    logic         z_valid;
    logic [1:0]   sel_q;
    logic         sel_chg;
`ifdef MUX4_REG_PARITY_EN
    logic         z_par;
`endif

    int total = 0;
    int bad   = 0;

    mux4_reg #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .sel     (sel),
        .z_comb  (z_comb),
        .z       (z),
        .z_valid (z_valid),
        .sel_q   (sel_q),
`ifdef MUX4_REG_PARITY_EN
        .z_par   (z_par),
`endif
        .sel_chg (sel_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] walk_exp [4];

    initial begin
        walk_exp[0] = 4'h1;
        walk_exp[1] = 4'h2;
        walk_exp[2] = 4'h4;
        walk_exp[3] = 4'h8;

        rst = 1'b0; en = 1'b0; sel = 2'd0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_z",       64'(z),       64'h0);
        chk("rst_valid",   64'(z_valid), 64'h0);
        chk("rst_sel_q",   64'(sel_q),   64'h0);
        chk("rst_sel_chg", 64'(sel_chg), 64'h0);
`ifdef MUX4_REG_PARITY_EN
        chk("rst_par",     64'(z_par),   64'h0);
`endif
        tick();
        chk("rst_hold_z",  64'(z),       64'h0);
        rst = 1'b0;

        // d0 toggle
        en = 1'b1; sel = 2'd0; d0 = 4'h1;
        #1 chk("tog_comb1", 64'(z_comb), 64'h1);
        tick();
        chk("tog_z1",       64'(z),       64'h1);
        chk("tog_valid1",   64'(z_valid), 64'h1);
        chk("tog_chg1",     64'(sel_chg), 64'h0);
        d0 = 4'h0;
        #1 chk("tog_comb0", 64'(z_comb), 64'h0);
        chk("tog_z_between", 64'(z),     64'h1);
        tick();
        chk("tog_z0",       64'(z),       64'h0);
        chk("tog_chg0",     64'(sel_chg), 64'h0);

        // en=0 gap, then select walk
        en = 1'b0;
        tick();
        chk("gap_valid",    64'(z_valid), 64'h0);
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h4; d3 = 4'h8;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1 chk($sformatf("walk_comb%0d", i), 64'(z_comb), 64'(walk_exp[i]));
            tick();
            chk($sformatf("walk_z%0d", i),     64'(z),       64'(walk_exp[i]));
            chk($sformatf("walk_selq%0d", i),  64'(sel_q),   64'(i));
            chk($sformatf("walk_chg%0d", i),   64'(sel_chg), (i == 0) ? 64'h0 : 64'h1);
        end

        // Reset mid-stream
        sel = 2'd1;
        tick();
        chk("mid_chg_pre",  64'(sel_chg), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_z",     64'(z),       64'h0);
        chk("mid_rst_valid", 64'(z_valid), 64'h0);
        chk("mid_rst_selq",  64'(sel_q),   64'h0);
        chk("mid_rst_chg",   64'(sel_chg), 64'h0);
        chk("mid_rst_comb",  64'(z_comb),  64'h2);
        tick();
        chk("mid_rst_hold",  64'(z_valid), 64'h0);
        rst = 1'b0;
        sel = 2'd2;
        tick();
        chk("post_rst_z",     64'(z),       64'h4);
        chk("post_rst_valid", 64'(z_valid), 64'h1);
        chk("post_rst_chg",   64'(sel_chg), 64'h0);

        // Hold with en=0
        d2 = 4'hA;
        tick();
        chk("hold_cap_z",   64'(z),       64'hA);
        chk("hold_cap_chg", 64'(sel_chg), 64'h0);
        en = 1'b0; d2 = 4'h5;
        #1 chk("hold_comb", 64'(z_comb),  64'h5);
        tick();
        chk("hold_z",       64'(z),       64'hA);
        chk("hold_valid",   64'(z_valid), 64'h0);
        chk("hold_selq",    64'(sel_q),   64'h2);
        chk("hold_chg",     64'(sel_chg), 64'h0);

`ifdef MUX4_REG_PARITY_EN
        en = 1'b1; d2 = 4'h7;
        tick();
        chk("par_7", 64'(z_par), 64'h1);
        d2 = 4'h3;
        tick();
        chk("par_3", 64'(z_par), 64'h0);
        en = 1'b0; d2 = 4'h1;
        tick();
        chk("par_hold", 64'(z_par), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
